// File: rtl/mmio_uart_tx.sv
// ----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter sitting on the core's data bus.
//   Bytes written to TXDATA are queued in a small FIFO. The serialiser pulls
//   them one at a time and shifts them out LSB first on tx. Register reads are
//   combinational, so a single-cycle core can finish a lw in one cycle. The
//   top level uses hit to choose between RAM and this block for data_from_mem.
//
//   Register window (8 bytes at BASE_ADDR; address_to_mem[1:0] ignored):
//     +0 TXDATA  W: push data_to_mem[7:0]      R: 0
//     +4 STATUS  R: [0] full, [1] empty, [2] busy, [3] overflow (sticky),
//                   [15:8] FIFO occupancy
//                W: data_to_mem[3]=1 clears overflow
//
// Ports
//   clk             in   1   clock
//   reset           in   1   synchronous, active-high
//   WE              in   1   bus write enable
//   address_to_mem  in   32  bus address
//   data_to_mem     in   32  bus write data
//   data_from_mem   out  32  read data (0 when hit=0)
//   hit             out  1   address falls inside the register window
//   tx              out  1   serial line, idle high (registered)
// ----------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic        hit,
    output logic        tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and control
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    // Serialiser
    state_t           r_state;
    logic [CLK_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_tx;

    // Bus decode and handshake wires
    logic        w_hit;
    logic        w_sel_status;
    logic        w_push_req;
    logic        w_ctrl_wr;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_ovf_clr;
    logic        w_bit_end;
    logic [31:0] w_status;
    logic        w_unused_bits;

    assign w_hit        = (address_to_mem[31:3] == BASE_ADDR[31:3]);
    assign w_sel_status = address_to_mem[2];
    assign w_push_req   = w_hit & WE & ~w_sel_status;
    assign w_ctrl_wr    = w_hit & WE &  w_sel_status;

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_push    = w_push_req & (~w_full | w_pop);
    assign w_drop    = w_push_req & ~w_push;
    assign w_ovf_clr = w_ctrl_wr & data_to_mem[3];
    assign w_bit_end = (r_clk_cnt == CLK_LAST);

    // Only the low byte of write data and address bits [31:2] are decoded.
    assign w_unused_bits = ^{data_to_mem[31:8], address_to_mem[1:0]};

    always_comb begin
        w_status       = 32'h0;
        w_status[0]    = w_full;
        w_status[1]    = w_empty;
        w_status[2]    = (r_state != S_IDLE);
        w_status[3]    = r_overflow;
        w_status[15:8] = 8'(r_count);
    end

    assign hit           = w_hit;
    assign data_from_mem = (w_hit & w_sel_status) ? w_status : 32'h0;
    assign tx            = r_tx;

    // FIFO data array: no reset, contents are only meaningful below r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_to_mem[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A dropped byte on the same edge as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Shift register: loaded on pop, shifted at the end of every data bit.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
        end else if ((r_state == S_DATA) && w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    // Frame sequencer with registered tx
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (w_pop) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CLK_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_STOP;
                            r_tx      <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            // r_shift[0] is the bit on the line; [1] is next.
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CLK_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CLK_W'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_tx      <= 1'b1;
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
//   Stimulus pushes every byte it expects to see on the line into exp_q; an
//   independent monitor decodes frames from tx and pops/compares.
// ----------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic        hit;
    logic        tx;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .WE            (WE),
        .address_to_mem(address_to_mem),
        .data_to_mem   (data_to_mem),
        .data_from_mem (data_from_mem),
        .hit           (hit),
        .tx            (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bus write; it lands on the next posedge. Returns 1ns after it.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input bit sent);
        WE             = 1'b1;
        address_to_mem = addr;
        data_to_mem    = data;
        @(posedge clk);
        #1;
        WE          = 1'b0;
        data_to_mem = 32'h0;
        if (sent) exp_q.push_back(data[7:0]);
    endtask

    task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string name);
        WE             = 1'b0;
        address_to_mem = addr;
        #1;
        check(name, data_from_mem, exp);
    endtask

    // Poll STATUS until idle/empty, bounded; a timeout shows as a failed compare.
    task automatic wait_idle(input int max_cyc, input string name);
        WE             = 1'b0;
        address_to_mem = BASE + 32'd4;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (data_from_mem == 32'h2) break;
        end
        check(name, data_from_mem, 32'h2);
    endtask

    function automatic logic exp_tx55(input int c);
        logic [7:0] b;
        b = 8'h55;
        if (c < CPB) return 1'b0;
        if (c < 9 * CPB) return b[(c - CPB) / CPB];
        return 1'b1;
    endfunction

    // Frame monitor: samples each bit 1.5 clocks after it starts.
    initial begin
        logic [9:0] smp;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    for (int k = 0; k < ((s == 0) ? 1 : CPB); k++) begin
                        @(negedge clk);
                        if (reset === 1'b1) aborted = 1'b1;
                    end
                    smp[s] = tx;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got byte %h, expected no frame", smp[8:1]);
                    end else begin
                        check("rx_byte", 32'(smp[8:1]), 32'(exp_q.pop_front()));
                        check("rx_framing", 32'({smp[9], smp[0]}), 32'h2);
                    end
                end
            end
        end
    end

    initial begin
        int bad;
        reset          = 1'b1;
        WE             = 1'b0;
        address_to_mem = BASE + 32'd4;
        data_to_mem    = 32'h0;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        read_check(BASE + 32'd4, 32'h2, "t1_status");
        check("t1_tx", 32'(tx), 32'h1);
        check("t1_hit", 32'(hit), 32'h1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 2: single byte 0x55, exact waveform and latency
        bus_write(BASE, 32'h0000_0055, 1'b1);
        bad = 0;
        for (int c = 0; c <= 10 * CPB; c++) begin
            @(posedge clk);
            #1;
            if (tx !== exp_tx55(c)) bad++;
            if (c == 20) read_check(BASE + 32'd4, 32'h6, "t2_busy");
        end
        check("t2_wave_errs", 32'(bad), 32'h0);
        read_check(BASE + 32'd4, 32'h2, "t2_status_after");

        // 3: six back-to-back writes, sixth is dropped
        for (int i = 1; i <= 6; i++) begin
            bus_write(BASE, 32'(i), (i <= 5));
        end
        read_check(BASE + 32'd4, 32'h0000_040D, "t3_status_full_ovf");

        // 4: clear overflow, rest of STATUS unchanged
        bus_write(BASE + 32'd4, 32'h0000_0008, 1'b0);
        read_check(BASE + 32'd4, 32'h0000_0405, "t4_status_clr");
        wait_idle(300, "t4_drain");
        check("t4_queue_empty", 32'(exp_q.size()), 32'h0);

        // 5: reset 12 cycles into a frame with two bytes queued
        bus_write(BASE, 32'h0000_00A1, 1'b1);
        bus_write(BASE, 32'h0000_00B2, 1'b1);
        bus_write(BASE, 32'h0000_00C3, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5_tx_after_reset", 32'(tx), 32'h1);
        read_check(BASE + 32'd4, 32'h2, "t5_status");
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) bad++;
        end
        check("t5_no_start_bits", 32'(bad), 32'h0);

        // 6: writes outside the window or with WE=0 do nothing
        bus_write(32'h0000_0100, 32'h0000_0077, 1'b0);
        read_check(32'h0000_0100, 32'h0, "t6_data_nohit");
        check("t6_hit_low", 32'(hit), 32'h0);
        read_check(BASE + 32'd8, 32'h0, "t6_data_base8");
        check("t6_hit_base8", 32'(hit), 32'h0);
        WE             = 1'b0;
        address_to_mem = BASE;
        data_to_mem    = 32'h0000_0099;
        @(posedge clk);
        #1;
        data_to_mem = 32'h0;
        read_check(BASE, 32'h0, "t6_txdata_reads_zero");
        check("t6_hit_base", 32'(hit), 32'h1);
        read_check(BASE + 32'd7, 32'h2, "t6_status_count0");
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) bad++;
        end
        check("t6_tx_idle", 32'(bad), 32'h0);

        repeat (10) @(posedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
